// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_pkg
//  Purpose  : Shared definitions for the instruction fetch stage: default
//             address/data widths, the default ack timeout and the fetch
//             state encoding.
//  Contents : INST_DEPTH    default instruction address width
//             INST_WIDTH    default instruction word width
//             FETCH_TIMEOUT default ack wait limit (cycles, 1..255)
//             if_state_e    3-bit fetch state encoding
//  Revision : 1.0  initial release
// ============================================================================
package inst_fetch_pkg;

  localparam int INST_DEPTH    = 8;
  localparam int INST_WIDTH    = 16;
  localparam int FETCH_TIMEOUT = 15;

  // IF_ERR is only reachable when the ack timeout is compiled in.
  typedef enum logic [2:0] {
    IF_IDLE  = 3'd0,
    IF_REQ   = 3'd1,
    IF_DRAIN = 3'd2,
    IF_HOLD  = 3'd3,
    IF_ERR   = 3'd4
  } if_state_e;

endpackage
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch
//  Purpose  : Fetch stage between the program counter and the decoder. Issues
//             a req/ack read of instruction memory at pc_addr_i, captures the
//             word in an instruction register and hands it to decode with a
//             valid/ready handshake. pc_count_o pulses once per captured word.
//             flush_i drops the IR and any in-flight word.
//  Config   : FETCH_TIMEOUT_EN - when defined, an 8-bit ack wait counter moves
//             the stage into a sticky error state after TIMEOUT wait cycles.
//             When undefined there is no counter and fetch_err_o is 0.
//  Ports    : clk           clock, rising edge
//             rst_n         asynchronous active-low reset
//             en_i          fetch enable (0 blocks new requests only)
//             flush_i       jump taken: drop IR and in-flight word
//             pc_addr_i     current PC value
//             pc_count_o    PC increment request (combinational)
//             imem_req_o    memory read request (registered)
//             imem_addr_o   memory read address (registered)
//             imem_ack_i    memory ack, rdata valid same cycle
//             imem_rdata_i  memory read data
//             ir_valid_o    IR holds a valid instruction
//             ir_data_o     instruction word
//             ir_addr_o     address of ir_data_o
//             ir_ready_i    decode accepts IR this cycle
//             fetch_err_o   sticky ack timeout flag
//  Revision : 1.0  initial release
// ============================================================================
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int AW      = INST_DEPTH,
  parameter int DW      = INST_WIDTH,
  parameter int TIMEOUT = FETCH_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          flush_i,
  input  logic [AW-1:0] pc_addr_i,
  output logic          pc_count_o,
  output logic          imem_req_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic          imem_ack_i,
  input  logic [DW-1:0] imem_rdata_i,
  output logic          ir_valid_o,
  output logic [DW-1:0] ir_data_o,
  output logic [AW-1:0] ir_addr_o,
  input  logic          ir_ready_i,
  output logic          fetch_err_o
);

  if_state_e     state_q, state_d;

  logic          req_q,   req_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic          irv_q,   irv_d;
  logic [DW-1:0] ird_q,   ird_d;
  logic [AW-1:0] ira_q,   ira_d;

  logic          timeout_hit;
  logic          capture;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic          err_q, err_d;

  // Fires on the wait cycle that brings the count up to TIMEOUT.
  assign timeout_hit = !imem_ack_i && ((wait_cnt_q + 8'd1) == 8'(TIMEOUT));
`else
  logic          unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IF_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IF_IDLE: begin
        if (en_i && !flush_i) state_d = IF_REQ;
      end
      IF_REQ: begin
        // A pending read cannot be withdrawn, so a flush without ack
        // parks in DRAIN until the memory answers.
        if (imem_ack_i)       state_d = flush_i ? IF_IDLE : IF_HOLD;
        else if (timeout_hit) state_d = IF_ERR;
        else if (flush_i)     state_d = IF_DRAIN;
      end
      IF_DRAIN: begin
        if (imem_ack_i)       state_d = IF_IDLE;
        else if (timeout_hit) state_d = IF_ERR;
      end
      IF_HOLD: begin
        if (flush_i)         state_d = IF_IDLE;
        else if (ir_ready_i) state_d = en_i ? IF_REQ : IF_IDLE;
      end
      IF_ERR: begin
        state_d = IF_ERR;
      end
      default: begin
        state_d = IF_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath next-value logic
  // --------------------------------------------------------------------------
  always_comb begin
    capture = (state_q == IF_REQ) && imem_ack_i && !flush_i;

    // The request line is high exactly while a read is outstanding.
    req_d  = (state_d == IF_REQ) || (state_d == IF_DRAIN);

    // A new address is taken only when a fresh read starts (from IDLE or
    // HOLD); while the read is pending the address must not move.
    addr_d = ((state_d == IF_REQ) && (state_q != IF_REQ)) ? pc_addr_i : addr_q;

    irv_d  = (state_d == IF_HOLD);
    ird_d  = capture ? imem_rdata_i : ird_q;
    ira_d  = capture ? addr_q       : ira_q;
  end

  assign pc_count_o = capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= 1'b0;
      addr_q <= '0;
      irv_q  <= 1'b0;
      ird_q  <= '0;
      ira_q  <= '0;
    end else begin
      req_q  <= req_d;
      addr_q <= addr_d;
      irv_q  <= irv_d;
      ird_q  <= ird_d;
      ira_q  <= ira_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // --------------------------------------------------------------------------
  // Ack wait counter and sticky error flag
  // --------------------------------------------------------------------------
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((state_d != state_q) && ((state_d == IF_REQ) || (state_d == IF_DRAIN))) begin
      wait_cnt_d = 8'd0;
    end else if (((state_q == IF_REQ) || (state_q == IF_DRAIN)) && !imem_ack_i) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
    err_d = err_q || (state_d == IF_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign fetch_err_o = err_q;
`else
  assign fetch_err_o = 1'b0;
`endif

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign ir_valid_o  = irv_q;
  assign ir_data_o   = ird_q;
  assign ir_addr_o   = ira_q;

endmodule
`default_nettype wire
